// File: rtl/matrix_stream_flatten.sv
// matrix_stream_flatten: packs IN_PAR-wide row-major chunks into one flattened DIM1 x DIM0 matrix word.
// Defining MATRIX_STREAM_FLATTEN_TRANSPOSE_EN adds a per-matrix transpose input for column-major output.
module matrix_stream_flatten #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM0       = 4,
  parameter int DIM1       = 4,
  parameter int IN_PAR     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
`ifdef MATRIX_STREAM_FLATTEN_TRANSPOSE_EN
  input  logic                           transpose,
`endif
  input  logic [DATA_WIDTH-1:0]          data_in [IN_PAR],
  input  logic                           data_in_valid,
  output logic                           data_in_ready,
  output logic [DATA_WIDTH*DIM0*DIM1-1:0] data_out,
  output logic                           data_out_valid,
  input  logic                           data_out_ready
);
  localparam int N_ELEM  = DIM0 * DIM1;
  localparam int N_BEATS = N_ELEM / IN_PAR;
  localparam int CW      = N_BEATS > 1 ? $clog2(N_BEATS) : 1;
  typedef enum logic {COLLECT, OUTPUT} state_t;
  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [DATA_WIDTH*N_ELEM-1:0] store_q, store_d;
  logic                         accept, last;
  assign accept = state_q == COLLECT && data_in_valid;
  assign last   = int'(cnt_q) == N_BEATS - 1;
`ifdef MATRIX_STREAM_FLATTEN_TRANSPOSE_EN
  logic tr_q, tr_d, tr;
  // beat 0 uses the live input so the whole matrix sees one orientation
  assign tr   = cnt_q == '0 ? transpose : tr_q;
  assign tr_d = accept && cnt_q == '0 ? transpose : tr_q;
`endif
  always_comb begin
    store_d = store_q;
    for (int i = 0; i < N_ELEM; i++)
      if (accept && int'(cnt_q) == i / IN_PAR)
`ifdef MATRIX_STREAM_FLATTEN_TRANSPOSE_EN
        store_d[(tr ? (i % DIM0) * DIM1 + i / DIM0 : i) * DATA_WIDTH +: DATA_WIDTH] = data_in[i % IN_PAR];
`else
        store_d[i * DATA_WIDTH +: DATA_WIDTH] = data_in[i % IN_PAR];
`endif
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      state_d = last ? OUTPUT : COLLECT;
    end
    if (state_q == OUTPUT && data_out_ready) state_d = COLLECT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      store_q <= '0;
`ifdef MATRIX_STREAM_FLATTEN_TRANSPOSE_EN
      tr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
`ifdef MATRIX_STREAM_FLATTEN_TRANSPOSE_EN
      tr_q    <= tr_d;
`endif
    end
  end
  assign data_out       = store_q;
  assign data_in_ready  = state_q == COLLECT;
  assign data_out_valid = state_q == OUTPUT;
endmodule

// File: doc/matrix_stream_flatten.md
MATRIX_STREAM_FLATTEN -- requirements
Module: matrix_stream_flatten

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: bit width of one matrix element.
REQ-002 SHALL have parameter DIM0, default 4: columns (inner, fastest-varying dimension).
REQ-003 SHALL have parameter DIM1, default 4: rows.
REQ-004 SHALL have parameter IN_PAR, default 4: elements per input beat; DIM0*DIM1 SHALL be an integer multiple of IN_PAR; N_BEATS = DIM0*DIM1/IN_PAR.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port data_in  input  DATA_WIDTH x IN_PAR (unpacked array)  one row-major chunk; data_in[0] is the lowest element index.
REQ-008 SHALL have port data_in_valid  input  1  chunk valid.
REQ-009 SHALL have port data_in_ready  output  1  chunk accepted when valid and ready are both high.
REQ-010 SHALL have port data_out  output  DATA_WIDTH*DIM0*DIM1  flattened matrix; slot k occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
REQ-011 SHALL have port data_out_valid  output  1  flattened matrix available.
REQ-012 SHALL have port data_out_ready  input  1  downstream accepts data_out.

Function
REQ-013 SHALL implement a two-state FSM: COLLECT (data_in_ready=1, data_out_valid=0) and OUTPUT (data_in_ready=0, data_out_valid=1).
REQ-014 SHALL keep a beat counter 0..N_BEATS-1; on each accepted beat b, element data_in[j] SHALL be stored at element index b*IN_PAR+j.
REQ-015 SHALL, on acceptance of beat N_BEATS-1, wrap the counter to 0 and enter OUTPUT on the next edge; data_out_valid SHALL rise exactly one cycle after the last accepted beat.
REQ-016 SHALL, in OUTPUT, hold data_out and data_out_valid stable until data_out_ready is high, then return to COLLECT on the next edge.
REQ-017 SHALL NOT accept input beats in OUTPUT; the first beat of the next matrix is accepted no earlier than the cycle after the output handshake.
REQ-018 SHALL, in default (row-major) mode, place element index i = r*DIM0+c in data_out slot i.
REQ-019 SHALL leave the counter and stored elements unchanged in COLLECT cycles where data_in_valid is low (bubbles of any length tolerated).
REQ-020 SHALL drive data_in_ready and data_out_valid directly from the state register, with no combinational path from any input.
REQ-021 SHALL, for N_BEATS=1, enter OUTPUT after every accepted beat.

Reset
REQ-022 SHALL, on rst high, asynchronously force state=COLLECT, beat counter=0, data_out_valid=0, data_in_ready=1 (while rst is deasserted) and the data_out storage to all zeros.
REQ-023 SHALL, on reset mid-matrix or during OUTPUT, discard all partial/held data; the first beat after reset release is beat 0 of a new matrix.

Configuration
REQ-024 SHALL, when macro MATRIX_STREAM_FLATTEN_TRANSPOSE_EN is defined, add input port transpose (1 bit), sampled on acceptance of beat 0 and held for that matrix; when that latched value is 1, element (r,c) SHALL be placed in slot c*DIM1+r (column-major output), otherwise REQ-018 applies.
REQ-025 SHALL, without MATRIX_STREAM_FLATTEN_TRANSPOSE_EN, have no transpose port and always produce row-major output, with no added logic.

Verification
REQ-026 SHALL verify: defaults, elements 0..15 in 4 back-to-back beats, data_out_ready=1 -> data_out_valid high the cycle after beat 3, slot k = k, ready returns high the next cycle.
REQ-027 SHALL verify: same stream with valid low for 3 cycles between beats 1 and 2 -> identical data_out, valid one cycle after final beat.
REQ-028 SHALL verify: data_out_ready held low 10 cycles in OUTPUT -> data_out stable, data_in_ready=0 throughout, valid beats presented are not consumed.
REQ-029 SHALL verify: rst pulsed after beat 2 of 4, then 4 fresh beats 100..115 -> data_out slots hold 100..115 only.
REQ-030 SHALL verify (TRANSPOSE_EN defined): transpose=1 at beat 0, elements 0..15, DIM0=DIM1=4 -> slot 1 = 4, slot 4 = 1, slot 15 = 15; transpose toggled after beat 0 has no effect.
REQ-031 SHALL verify: DIM0=3, DIM1=2, IN_PAR=6 -> single beat 0..5 yields slots 0..5 and OUTPUT entered after every beat.
